rf_wb_arbiter: RTL and testbench

RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

---
 rtl/rf_pkg.sv | 12 +
 rtl/rf_wb_fifo.sv | 84 ++++++++
 rtl/rf_wb_arbiter.sv | 134 +++++++++++++
 tb/tb_rf_wb_arbiter.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared definitions for the register-file write-back arbiter.
//   REG_ADDR_W     : register address width (32 architectural registers)
//   DEFAULT_DATA_W : default register data width
//   ZERO_REG       : hard-wired zero register, never written
package rf_pkg;

    localparam int unsigned REG_ADDR_W     = 5;
    localparam int unsigned DEFAULT_DATA_W = 32;

    localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;

endpackage

// File: rtl/rf_wb_fifo.sv
// Small in-order FIFO buffering multicycle-unit write-backs.
// Ports:
//   clk, rst             : clock, asynchronous active-high reset (empties the FIFO)
//   push, push_rd/data   : enqueue one entry (ignored when full)
//   pop                  : dequeue the head entry (ignored when empty)
//   full, empty          : occupancy flags
//   head_rd, head_data   : oldest entry; only meaningful when empty=0
module rf_wb_fifo
    import rf_pkg::*;
#(
    parameter int unsigned DATA_W = DEFAULT_DATA_W,
    parameter int unsigned DEPTH  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [REG_ADDR_W-1:0] push_rd,
    input  logic [DATA_W-1:0]     push_data,
    input  logic                  pop,
    output logic                  full,
    output logic                  empty,
    output logic [REG_ADDR_W-1:0] head_rd,
    output logic [DATA_W-1:0]     head_data
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [REG_ADDR_W-1:0] rd_mem   [DEPTH];
    logic [DATA_W-1:0]     data_mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic do_push, do_pop;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign head_rd   = rd_mem[rd_ptr_q];
    assign head_data = data_mem[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage needs no reset; occupancy is tracked by count_q.
    always_ff @(posedge clk) begin
        if (do_push) begin
            rd_mem[wr_ptr_q]   <= push_rd;
            data_mem[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter between the pipeline write-back (A) and a
// buffered multicycle unit (B), with a pending-write scoreboard and starvation hint.
// Ports:
//   clk, rst                    : clock, asynchronous active-high reset
//   a_valid/a_rd/a_data         : pipeline write-back, always wins the port
//   b_valid/b_ready/b_rd/b_data : multicycle write-back into the FIFO
//   issue_valid/issue_rd        : multicycle op issue, sets the scoreboard
//   issue_stall                 : issue must be held this cycle
//   rs/rt, rs_busy/rt_busy      : decode lookups of pending multicycle writes
//   rf_we/rf_rd/rf_wdata        : register-file write port
//   wb_hold                     : ask upstream to bubble write-back next cycle
module rf_wb_arbiter
    import rf_pkg::*;
#(
    parameter int unsigned DATA_W     = DEFAULT_DATA_W,
    parameter int unsigned FIFO_DEPTH = 2,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  a_valid,
    input  logic [REG_ADDR_W-1:0] a_rd,
    input  logic [DATA_W-1:0]     a_data,
    input  logic                  b_valid,
    output logic                  b_ready,
    input  logic [REG_ADDR_W-1:0] b_rd,
    input  logic [DATA_W-1:0]     b_data,
    input  logic                  issue_valid,
    input  logic [REG_ADDR_W-1:0] issue_rd,
    output logic                  issue_stall,
    input  logic [REG_ADDR_W-1:0] rs,
    input  logic [REG_ADDR_W-1:0] rt,
    output logic                  rs_busy,
    output logic                  rt_busy,
    output logic                  rf_we,
    output logic [REG_ADDR_W-1:0] rf_rd,
    output logic [DATA_W-1:0]     rf_wdata,
    output logic                  wb_hold
);

    localparam int unsigned STARVE_W = $clog2(STARVE_MAX + 1);

    logic                  fifo_full, fifo_empty;
    logic                  fifo_push, fifo_pop;
    logic [REG_ADDR_W-1:0] head_rd;
    logic [DATA_W-1:0]     head_data;

    logic live_a;
    logic b_commit;
    logic sb_set;

    logic [31:0]         pending_q, pending_d;
    logic [STARVE_W-1:0] starve_q, starve_d;

    rf_wb_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_rd   (b_rd),
        .push_data (b_data),
        .pop       (fifo_pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head_rd   (head_rd),
        .head_data (head_data)
    );

    assign live_a    = a_valid && (a_rd != ZERO_REG);
    assign b_ready   = !rst && !fifo_full;
    assign fifo_push = b_valid && b_ready;
    // The head leaves whenever A does not claim the port; rd=0 heads drain silently.
    assign fifo_pop  = !rst && !live_a && !fifo_empty;
    assign b_commit  = fifo_pop && (head_rd != ZERO_REG);

    // A register being committed this cycle frees its slot for a new issue.
    assign issue_stall = !rst && (fifo_full ||
                         (issue_valid && (issue_rd != ZERO_REG) && pending_q[issue_rd] &&
                          !(b_commit && (head_rd == issue_rd))));
    assign sb_set      = issue_valid && (issue_rd != ZERO_REG) && !issue_stall;

    assign rs_busy = !rst && pending_q[rs];
    assign rt_busy = !rst && pending_q[rt];
    assign wb_hold = !rst && (starve_q == STARVE_W'(STARVE_MAX));

    always_comb begin
        rf_we    = 1'b0;
        rf_rd    = '0;
        rf_wdata = '0;
        if (live_a) begin
            rf_we    = !rst;
            rf_rd    = rst ? ZERO_REG : a_rd;
            rf_wdata = rst ? '0 : a_data;
        end else if (b_commit) begin
            rf_we    = 1'b1;
            rf_rd    = head_rd;
            rf_wdata = head_data;
        end
    end

    always_comb begin
        pending_d = pending_q;
        if (b_commit) begin
            pending_d[head_rd] = 1'b0;
        end
        // Set after clear so a same-register set wins.
        if (sb_set) begin
            pending_d[issue_rd] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_comb begin
        starve_d = starve_q;
        if (fifo_pop || fifo_empty) begin
            starve_d = '0;
        end else if (starve_q != STARVE_W'(STARVE_MAX)) begin
            starve_d = starve_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q <= '0;
            starve_q  <= '0;
        end else begin
            pending_q <= pending_d;
            starve_q  <= starve_d;
        end
    end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
module tb_rf_wb_arbiter;

    localparam int DW    = 32;
    localparam int DEPTH = 2;
    localparam int SMAX  = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          a_valid;
    logic [4:0]    a_rd;
    logic [DW-1:0] a_data;
    logic          b_valid;
    logic          b_ready;
    logic [4:0]    b_rd;
    logic [DW-1:0] b_data;
    logic          issue_valid;
    logic [4:0]    issue_rd;
    logic          issue_stall;
    logic [4:0]    rs;
    logic [4:0]    rt;
    logic          rs_busy;
    logic          rt_busy;
    logic          rf_we;
    logic [4:0]    rf_rd;
    logic [DW-1:0] rf_wdata;
    logic          wb_hold;

    always #5 clk = ~clk;

    rf_wb_arbiter #(
        .DATA_W     (DW),
        .FIFO_DEPTH (DEPTH),
        .STARVE_MAX (SMAX)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .a_valid     (a_valid),
        .a_rd        (a_rd),
        .a_data      (a_data),
        .b_valid     (b_valid),
        .b_ready     (b_ready),
        .b_rd        (b_rd),
        .b_data      (b_data),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .issue_stall (issue_stall),
        .rs          (rs),
        .rt          (rt),
        .rs_busy     (rs_busy),
        .rt_busy     (rt_busy),
        .rf_we       (rf_we),
        .rf_rd       (rf_rd),
        .rf_wdata    (rf_wdata),
        .wb_hold     (wb_hold)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: a queue of buffered writes, a bit per register, a wait counter.
    typedef struct {
        logic [4:0]    rd;
        logic [DW-1:0] data;
    } beat_t;

    beat_t    q[$];
    bit [31:0] pend;
    int        starve;

    // Inputs are set at posedge+1; compare at posedge+2, then advance the model.
    task automatic eval_cycle();
        bit    live, full, empty, pop, commit, stall, exp_we;
        beat_t hd;
        logic [4:0]    exp_rd;
        logic [DW-1:0] exp_data;
        #1;
        if (rst) begin
            check_eq("rst_rf_we", rf_we, 0);
            check_eq("rst_rf_rd", rf_rd, 0);
            check_eq("rst_rf_wdata", rf_wdata, 0);
            check_eq("rst_b_ready", b_ready, 0);
            check_eq("rst_issue_stall", issue_stall, 0);
            check_eq("rst_wb_hold", wb_hold, 0);
            check_eq("rst_rs_busy", rs_busy, 0);
            check_eq("rst_rt_busy", rt_busy, 0);
            q.delete();
            pend   = '0;
            starve = 0;
            return;
        end
        live   = a_valid && (a_rd != 0);
        full   = (q.size() == DEPTH);
        empty  = (q.size() == 0);
        hd.rd   = '0;
        hd.data = '0;
        if (!empty) hd = q[0];
        pop    = !live && !empty;
        commit = pop && (hd.rd != 0);
        exp_we   = live || commit;
        exp_rd   = live ? a_rd : hd.rd;
        exp_data = live ? a_data : hd.data;
        stall  = full || (issue_valid && (issue_rd != 0) && pend[issue_rd] &&
                          !(commit && (hd.rd == issue_rd)));

        check_eq("rf_we", rf_we, exp_we);
        if (exp_we) begin
            check_eq("rf_rd", rf_rd, exp_rd);
            check_eq("rf_wdata", rf_wdata, exp_data);
        end
        check_eq("b_ready", b_ready, !full);
        check_eq("issue_stall", issue_stall, stall);
        check_eq("rs_busy", rs_busy, pend[rs]);
        check_eq("rt_busy", rt_busy, pend[rt]);
        check_eq("wb_hold", wb_hold, starve == SMAX);

        if (pop) void'(q.pop_front());
        if (b_valid && !full) q.push_back('{rd: b_rd, data: b_data});
        if (commit) pend[hd.rd] = 1'b0;
        if (issue_valid && (issue_rd != 0) && !stall) pend[issue_rd] = 1'b1;
        if (pop || empty) starve = 0;
        else if (starve < SMAX) starve++;
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        eval_cycle();
        advance();
    endtask

    task automatic idle();
        a_valid     = 0;
        a_rd        = 0;
        a_data      = 0;
        b_valid     = 0;
        b_rd        = 0;
        b_data      = 0;
        issue_valid = 0;
        issue_rd    = 0;
        rs          = 0;
        rt          = 0;
    endtask

    task automatic b_beat(input logic [4:0] rd, input logic [DW-1:0] data);
        b_valid = 1;
        b_rd    = rd;
        b_data  = data;
    endtask

    initial begin
        rst = 1;
        idle();
        q.delete();
        pend   = '0;
        starve = 0;
        tick();
        tick();
        rst = 0;

        // Live A with an empty FIFO wins combinationally.
        idle();
        a_valid = 1; a_rd = 5; a_data = 32'hDEAD_BEEF;
        eval_cycle();
        check_eq("a_win_we", rf_we, 1);
        check_eq("a_win_rd", rf_rd, 5);
        check_eq("a_win_data", rf_wdata, 32'hDEAD_BEEF);
        advance();

        // Scoreboard stays busy through the commit cycle, clears afterwards.
        idle(); issue_valid = 1; issue_rd = 8; tick();
        idle(); rt = 8; b_beat(8, 32'h11);
        eval_cycle();
        check_eq("sb8_busy_accept", rt_busy, 1);
        advance();
        idle(); rt = 8;
        eval_cycle();
        check_eq("sb8_commit_rd", rf_rd, 8);
        check_eq("sb8_commit_data", rf_wdata, 32'h11);
        check_eq("sb8_busy_commit", rt_busy, 1);
        advance();
        idle(); rt = 8;
        eval_cycle();
        check_eq("sb8_busy_after", rt_busy, 0);
        advance();

        // Two beats blocked by A: FIFO fills, starvation hint rises, then in-order drain.
        idle(); a_valid = 1; a_rd = 20; a_data = $urandom; b_beat(3, 32'h33); tick();
        a_data = $urandom; b_beat(4, 32'h44); tick();
        a_data = $urandom; b_beat(7, 32'h77);
        eval_cycle();
        check_eq("full_b_ready", b_ready, 0);
        check_eq("full_issue_stall", issue_stall, 1);
        advance();
        b_valid = 0;
        for (int i = 0; i < 4; i++) begin
            a_data = $urandom;
            eval_cycle();
            if (i == 2) begin
                check_eq("starve_hold", wb_hold, 1);
                check_eq("starve_a_wins", rf_rd, 20);
            end
            advance();
        end
        idle();
        eval_cycle(); check_eq("drain_first", rf_rd, 3); advance();
        eval_cycle(); check_eq("drain_second", rf_rd, 4); advance();
        eval_cycle(); check_eq("drain_done", rf_we, 0); advance();

        // Re-issue of a pending register stalls unless it commits that cycle.
        idle(); issue_valid = 1; issue_rd = 9; tick();
        idle(); issue_valid = 1; issue_rd = 9; rs = 9;
        eval_cycle(); check_eq("reissue_stall", issue_stall, 1); advance();
        idle(); rs = 9; b_beat(9, 32'h99); tick();
        idle(); issue_valid = 1; issue_rd = 9;
        eval_cycle();
        check_eq("reissue_commit_stall", issue_stall, 0);
        check_eq("reissue_commit_rd", rf_rd, 9);
        advance();
        idle(); rs = 9;
        eval_cycle(); check_eq("reissue_set_wins", rs_busy, 1); advance();
        idle(); b_beat(9, 32'h98); tick();
        idle(); tick();

        // a_rd=0 does not claim the port; rd=0 beats drain silently.
        idle(); a_valid = 1; a_rd = 20; b_beat(6, 32'h66); tick();
        idle(); a_valid = 1; a_rd = 0; a_data = 32'hBAD0_BAD0;
        eval_cycle();
        check_eq("a_zero_we", rf_we, 1);
        check_eq("a_zero_rd", rf_rd, 6);
        check_eq("a_zero_data", rf_wdata, 32'h66);
        advance();
        idle(); b_beat(0, 32'h77); tick();
        idle(); eval_cycle(); check_eq("b_zero_we", rf_we, 0); advance();
        idle(); eval_cycle(); check_eq("b_zero_ready", b_ready, 1); advance();

        // Mid-operation reset discards buffered writes and the scoreboard.
        idle(); issue_valid = 1; issue_rd = 12; a_valid = 1; a_rd = 20; b_beat(13, 1); tick();
        idle(); a_valid = 1; a_rd = 20; b_beat(14, 2); tick();
        idle(); rst = 1; a_valid = 1; a_rd = 5; issue_valid = 1; issue_rd = 3; rs = 12;
        eval_cycle();
        check_eq("rst_mid_we", rf_we, 0);
        advance();
        rst = 0;
        idle(); rs = 12;
        eval_cycle();
        check_eq("post_rst_we", rf_we, 0);
        check_eq("post_rst_busy12", rs_busy, 0);
        advance();
        idle(); b_beat(15, 3); tick();
        idle(); eval_cycle(); check_eq("post_rst_first_commit", rf_rd, 15); advance();

        // Randomized traffic against the model.
        for (int n = 0; n < 600; n++) begin
            rst         = ($urandom_range(0, 99) == 0);
            a_valid     = ($urandom_range(0, 9) < 4);
            a_rd        = 5'($urandom_range(0, 15));
            a_data      = $urandom;
            b_valid     = $urandom_range(0, 1);
            b_rd        = 5'($urandom_range(0, 15));
            b_data      = $urandom;
            issue_valid = $urandom_range(0, 1);
            issue_rd    = 5'($urandom_range(0, 15));
            rs          = 5'($urandom_range(0, 15));
            rt          = 5'($urandom_range(0, 15));
            tick();
        end
        rst = 0;
        idle();
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
